// File: rtl/wb_core_arbiter.sv
// wb_core_arbiter: two-master Wishbone arbiter in front of a single interconnect master port.
//   Master 0 is the instruction-fetch port, master 1 the load/store port.
//   A grant is held for as long as the granted master keeps cyc high (bursts included),
//   then one IDLE cycle is spent before the next grant. Simultaneous requests from IDLE
//   alternate round-robin, with master 0 favoured after reset.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to compile in a bus watchdog that terminates a
// transfer with err after TIMEOUT_CYCLES unanswered strobe cycles.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   wbmN_adr_i/dat_i/sel_i/we_i   master N request (N = 0, 1)
//   wbmN_cyc_i/stb_i/cti_i/bte_i  master N cycle qualifiers
//   wbmN_dat_o                    read data, always equal to wb_io_dat_i
//   wbmN_ack_o/err_o/rty_o        responses, only toward the granted master
//   wb_io_*_o                     routed request toward the interconnect (zero when idle)
//   wb_io_dat_i/ack_i/err_i/rty_i interconnect responses
module wb_core_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wbm0_adr_i,
  input  logic [31:0] wbm0_dat_i,
  input  logic [3:0]  wbm0_sel_i,
  input  logic        wbm0_we_i,
  input  logic        wbm0_cyc_i,
  input  logic        wbm0_stb_i,
  input  logic [2:0]  wbm0_cti_i,
  input  logic [1:0]  wbm0_bte_i,
  output logic [31:0] wbm0_dat_o,
  output logic        wbm0_ack_o,
  output logic        wbm0_err_o,
  output logic        wbm0_rty_o,
  input  logic [31:0] wbm1_adr_i,
  input  logic [31:0] wbm1_dat_i,
  input  logic [3:0]  wbm1_sel_i,
  input  logic        wbm1_we_i,
  input  logic        wbm1_cyc_i,
  input  logic        wbm1_stb_i,
  input  logic [2:0]  wbm1_cti_i,
  input  logic [1:0]  wbm1_bte_i,
  output logic [31:0] wbm1_dat_o,
  output logic        wbm1_ack_o,
  output logic        wbm1_err_o,
  output logic        wbm1_rty_o,
  output logic [31:0] wb_io_adr_o,
  output logic [31:0] wb_io_dat_o,
  output logic [3:0]  wb_io_sel_o,
  output logic        wb_io_we_o,
  output logic        wb_io_cyc_o,
  output logic        wb_io_stb_o,
  output logic [2:0]  wb_io_cti_o,
  output logic [1:0]  wb_io_bte_o,
  input  logic [31:0] wb_io_dat_i,
  input  logic        wb_io_ack_i,
  input  logic        wb_io_err_i,
  input  logic        wb_io_rty_i
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_core_arbiter: TIMEOUT_CYCLES must lie in 2..65535");
  end

  typedef enum logic [1:0] {StIdle = 2'd0, StGnt0 = 2'd1, StGnt1 = 2'd2} state_e;

  state_e r_state;
  // Set when master 0 was served last, i.e. master 1 wins the next tie. Cleared by reset.
  logic   r_prio1;
  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_timeout;

  // Reset also masks the grant so outputs are quiet for the whole reset pulse.
  assign w_gnt0 = (r_state == StGnt0) && !wb_rst_i;
  assign w_gnt1 = (r_state == StGnt1) && !wb_rst_i;

  assign wbm0_dat_o = wb_io_dat_i;
  assign wbm1_dat_o = wb_io_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_tmo_cnt;
  logic        w_sel_stb;
  logic        w_resp;

  assign w_sel_stb = (w_gnt0 && wbm0_stb_i) || (w_gnt1 && wbm1_stb_i);
  assign w_resp    = wb_io_ack_i || wb_io_err_i || wb_io_rty_i;
  // Fires on the TIMEOUT_CYCLES-th consecutive unanswered strobe cycle.
  assign w_timeout = w_sel_stb && !w_resp && (r_tmo_cnt == TmoLast);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !(w_gnt0 || w_gnt1) || w_resp || w_timeout) begin
      r_tmo_cnt <= '0;
    end else if (w_sel_stb) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= StIdle;
      r_prio1 <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (wbm0_cyc_i && wbm1_cyc_i) begin
            r_state <= r_prio1 ? StGnt1 : StGnt0;
          end else if (wbm0_cyc_i) begin
            r_state <= StGnt0;
          end else if (wbm1_cyc_i) begin
            r_state <= StGnt1;
          end
        end
        StGnt0: begin
          if (!wbm0_cyc_i || w_timeout) begin
            r_state <= StIdle;
            r_prio1 <= 1'b1;
          end
        end
        StGnt1: begin
          if (!wbm1_cyc_i || w_timeout) begin
            r_state <= StIdle;
            r_prio1 <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    wb_io_adr_o = '0;
    wb_io_dat_o = '0;
    wb_io_sel_o = '0;
    wb_io_we_o  = 1'b0;
    wb_io_cyc_o = 1'b0;
    wb_io_stb_o = 1'b0;
    wb_io_cti_o = '0;
    wb_io_bte_o = '0;
    wbm0_ack_o  = 1'b0;
    wbm0_err_o  = 1'b0;
    wbm0_rty_o  = 1'b0;
    wbm1_ack_o  = 1'b0;
    wbm1_err_o  = 1'b0;
    wbm1_rty_o  = 1'b0;
    if (w_gnt0) begin
      wb_io_adr_o = wbm0_adr_i;
      wb_io_dat_o = wbm0_dat_i;
      wb_io_sel_o = wbm0_sel_i;
      wb_io_we_o  = wbm0_we_i;
      wb_io_cyc_o = wbm0_cyc_i;
      wb_io_stb_o = wbm0_stb_i;
      wb_io_cti_o = wbm0_cti_i;
      wb_io_bte_o = wbm0_bte_i;
      wbm0_ack_o  = wb_io_ack_i;
      wbm0_err_o  = wb_io_err_i;
      wbm0_rty_o  = wb_io_rty_i;
    end else if (w_gnt1) begin
      wb_io_adr_o = wbm1_adr_i;
      wb_io_dat_o = wbm1_dat_i;
      wb_io_sel_o = wbm1_sel_i;
      wb_io_we_o  = wbm1_we_i;
      wb_io_cyc_o = wbm1_cyc_i;
      wb_io_stb_o = wbm1_stb_i;
      wb_io_cti_o = wbm1_cti_i;
      wb_io_bte_o = wbm1_bte_i;
      wbm1_ack_o  = wb_io_ack_i;
      wbm1_err_o  = wb_io_err_i;
      wbm1_rty_o  = wb_io_rty_i;
    end
    if (w_timeout) begin
      // Abort toward the slave and hand the granted master an error instead.
      wb_io_cyc_o = 1'b0;
      wb_io_stb_o = 1'b0;
      wbm0_err_o  = w_gnt0;
      wbm1_err_o  = w_gnt1;
    end
  end

endmodule

// File: tb/tb_wb_core_arbiter.sv
// Self-checking bench for wb_core_arbiter: directed scenarios plus a randomized run scored
// against a transaction-level model of the arbitration rules.
module tb_wb_core_arbiter;

  localparam int unsigned Tmo = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [31:0] io_adr, io_dat;
  logic [3:0]  io_sel;
  logic        io_we, io_cyc, io_stb;
  logic [2:0]  io_cti;
  logic [1:0]  io_bte;
  logic [31:0] io_dat_i;
  logic        io_ack, io_err, io_rty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_core_arbiter #(.TIMEOUT_CYCLES(Tmo)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dat), .wbm0_sel_i(m0_sel), .wbm0_we_i(m0_we),
    .wbm0_cyc_i(m0_cyc), .wbm0_stb_i(m0_stb), .wbm0_cti_i(m0_cti), .wbm0_bte_i(m0_bte),
    .wbm0_dat_o(m0_dat_o), .wbm0_ack_o(m0_ack), .wbm0_err_o(m0_err), .wbm0_rty_o(m0_rty),
    .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dat), .wbm1_sel_i(m1_sel), .wbm1_we_i(m1_we),
    .wbm1_cyc_i(m1_cyc), .wbm1_stb_i(m1_stb), .wbm1_cti_i(m1_cti), .wbm1_bte_i(m1_bte),
    .wbm1_dat_o(m1_dat_o), .wbm1_ack_o(m1_ack), .wbm1_err_o(m1_err), .wbm1_rty_o(m1_rty),
    .wb_io_adr_o(io_adr), .wb_io_dat_o(io_dat), .wb_io_sel_o(io_sel), .wb_io_we_o(io_we),
    .wb_io_cyc_o(io_cyc), .wb_io_stb_o(io_stb), .wb_io_cti_o(io_cti), .wb_io_bte_o(io_bte),
    .wb_io_dat_i(io_dat_i), .wb_io_ack_i(io_ack), .wb_io_err_i(io_err), .wb_io_rty_i(io_rty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_drive(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic [2:0] cti, input logic [1:0] bte);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr;
      m0_dat = dat; m0_sel = sel; m0_cti = cti; m0_bte = bte;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr;
      m1_dat = dat; m1_sel = sel; m1_cti = cti; m1_bte = bte;
    end
  endtask

  task automatic m_idle(input int m);
    m_drive(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
  endtask

  task automatic s_drive(input logic ack, input logic err, input logic rty,
                         input logic [31:0] dat);
    io_ack = ack; io_err = err; io_rty = rty; io_dat_i = dat;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_idle(0);
    m_idle(1);
    s_drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_drive(0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 4'hF, 3'b010, 2'b01);
    m_drive(1, 1'b1, 1'b1, 1'b0, 32'h8765_4321, 32'h0FED_CBA9, 4'h3, 3'b111, 2'b10);
    s_drive(1'b1, 1'b1, 1'b1, 32'hCAFE_F00D);
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({io_adr, io_dat, io_sel, io_we, io_cyc, io_stb, io_cti, io_bte} !== 76'h0) begin
        errors++;
        $display("FAIL reset_io: got cyc=%b stb=%b adr=%h, expected all zero",
                 io_cyc, io_stb, io_adr);
      end
      checks++;
      if ({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty} !== 6'b0) begin
        errors++;
        $display("FAIL reset_resp: got %b expected 000000",
                 {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty});
      end
      checks++;
      if (m0_dat_o !== 32'hCAFE_F00D || m1_dat_o !== 32'hCAFE_F00D) begin
        errors++;
        $display("FAIL reset_dat: got %h/%h expected cafef00d", m0_dat_o, m1_dat_o);
      end
    end
    rst = 1'b0;
    m_idle(0);
    m_idle(1);
    s_drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if (io_cyc !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: io_cyc=%b expected 0", io_cyc);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    m_drive(0, 1'b1, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 3'b000, 2'b00);
    #1;
    checks++;
    if (io_cyc !== 1'b0) begin
      errors++;
      $display("FAIL read_latency_early: io_cyc=%b expected 0", io_cyc);
    end
    tick();
    checks++;
    if (io_cyc !== 1'b1 || io_stb !== 1'b1 || io_adr !== 32'h1000_0010 || io_we !== 1'b0) begin
      errors++;
      $display("FAIL read_grant: cyc=%b stb=%b adr=%h we=%b expected 1 1 10000010 0",
               io_cyc, io_stb, io_adr, io_we);
    end
    checks++;
    if (m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_no_early_ack: m0_ack=%b expected 0", m0_ack);
    end
    tick();
    s_drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_ack: m0_ack=%b m1_ack=%b expected 1 0", m0_ack, m1_ack);
    end
    checks++;
    if (m0_dat_o !== 32'hDEAD_BEEF || m1_dat_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_data: got %h/%h expected deadbeef", m0_dat_o, m1_dat_o);
    end
    tick();
    m_idle(0);
    s_drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (io_cyc !== 1'b0) begin
      errors++;
      $display("FAIL read_release: io_cyc=%b expected 0", io_cyc);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    m_drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_00A0, 32'h0, 4'hF, 3'b000, 2'b00);
    m_drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_00B0, 32'h1111_2222, 4'hF, 3'b000, 2'b00);
    tick();
    checks++;
    if (io_cyc !== 1'b1 || io_adr !== 32'h0000_00A0) begin
      errors++;
      $display("FAIL sim_first_m0: cyc=%b adr=%h expected 1 000000a0", io_cyc, io_adr);
    end
    s_drive(1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
    #1;
    checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL sim_ack0: m0_ack=%b m1_ack=%b expected 1 0", m0_ack, m1_ack);
    end
    tick();
    m_idle(0);
    s_drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (io_cyc !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL sim_release: cyc=%b m1_ack=%b expected 0 0", io_cyc, m1_ack);
    end
    tick();
    checks++;
    if (io_cyc !== 1'b0) begin
      errors++;
      $display("FAIL sim_idle_gap: io_cyc=%b expected 0", io_cyc);
    end
    tick();
    checks++;
    if (io_cyc !== 1'b1 || io_adr !== 32'h0000_00B0 || io_we !== 1'b1) begin
      errors++;
      $display("FAIL sim_second_m1: cyc=%b adr=%h we=%b expected 1 000000b0 1",
               io_cyc, io_adr, io_we);
    end
    s_drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL sim_ack1: m1_ack=%b m0_ack=%b expected 1 0", m1_ack, m0_ack);
    end
    tick();
    m_idle(1);
    s_drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_round_robin();
    int last = -1;
    int exp_g;
    int g;
    bit found;
    do_reset();
    m_drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 3'b000, 2'b00);
    m_drive(1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 3'b000, 2'b00);
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int w = 0; w < 6 && !found; w++) begin
        tick();
        if (io_cyc === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL rr_wait: no grant within 6 cycles for transfer %0d", k);
        return;
      end
      g = (io_adr == 32'h0000_2000) ? 1 : 0;
      exp_g = (last == 0) ? 1 : 0;
      checks++;
      if (g != exp_g) begin
        errors++;
        $display("FAIL rr_order: transfer %0d granted m%0d expected m%0d", k, g, exp_g);
      end
      last = exp_g;
      s_drive(1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      checks++;
      if ({m0_ack, m1_ack} !== ((g == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_ack: got m0/m1 ack %b%b for grant m%0d", m0_ack, m1_ack, g);
      end
      tick();
      m_drive(g, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
      s_drive(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      m_drive(g, 1'b1, 1'b1, 1'b0, (g == 0) ? 32'h0000_1000 : 32'h0000_2000, 32'h0, 4'hF,
              3'b000, 2'b00);
    end
    m_idle(0);
    m_idle(1);
    tick();
  endtask

  task automatic test_burst();
    logic [2:0] exp_cti;
    do_reset();
    m_drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_0000, 4'hF, 3'b010, 2'b00);
    tick();
    m_drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 3'b000, 2'b00);
    for (int b = 0; b < 4; b++) begin
      exp_cti = (b < 3) ? 3'b010 : 3'b111;
      m_drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_0100 + 32'(4 * b), 32'hA5A5_0000 + 32'(b), 4'hF,
              exp_cti, 2'b00);
      s_drive(1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      checks++;
      if (io_cyc !== 1'b1 || io_adr !== 32'h0000_0100 + 32'(4 * b) || io_cti !== exp_cti) begin
        errors++;
        $display("FAIL burst_route: beat %0d cyc=%b adr=%h cti=%b expected 1 %h %b", b,
                 io_cyc, io_adr, io_cti, 32'h0000_0100 + 32'(4 * b), exp_cti);
      end
      checks++;
      if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
        errors++;
        $display("FAIL burst_ack: beat %0d m1_ack=%b m0_ack=%b expected 1 0", b, m1_ack,
                 m0_ack);
      end
      tick();
    end
    m_idle(1);
    s_drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (io_cyc !== 1'b0) begin
      errors++;
      $display("FAIL burst_release: io_cyc=%b expected 0", io_cyc);
    end
    tick();
    checks++;
    if (io_cyc !== 1'b0) begin
      errors++;
      $display("FAIL burst_idle_gap: io_cyc=%b expected 0", io_cyc);
    end
    tick();
    checks++;
    if (io_cyc !== 1'b1 || io_adr !== 32'h0000_3000) begin
      errors++;
      $display("FAIL burst_then_m0: cyc=%b adr=%h expected 1 00003000", io_cyc, io_adr);
    end
    s_drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    m_idle(0);
    s_drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    m_drive(1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h5555_AAAA, 4'hF, 3'b000, 2'b00);
`ifdef WB_ARB_TIMEOUT_EN
    for (int n = 1; n <= int'(Tmo); n++) begin
      tick();
      checks++;
      if (n < int'(Tmo)) begin
        if (io_cyc !== 1'b1 || m1_err !== 1'b0) begin
          errors++;
          $display("FAIL tmo_wait: stb cycle %0d cyc=%b err=%b expected 1 0", n, io_cyc,
                   m1_err);
        end
      end else begin
        if (m1_err !== 1'b1 || io_cyc !== 1'b0 || io_stb !== 1'b0 || m0_err !== 1'b0) begin
          errors++;
          $display("FAIL tmo_fire: err1=%b cyc=%b stb=%b err0=%b expected 1 0 0 0", m1_err,
                   io_cyc, io_stb, m0_err);
        end
      end
    end
    tick();
    checks++;
    if (io_cyc !== 1'b0 || m1_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle: cyc=%b err=%b expected 0 0", io_cyc, m1_err);
    end
    m_idle(1);
    tick();
`else
    for (int n = 1; n <= 20; n++) begin
      tick();
      checks++;
      if (io_cyc !== 1'b1 || m1_err !== 1'b0) begin
        errors++;
        $display("FAIL hung_stall: cycle %0d cyc=%b err=%b expected 1 0", n, io_cyc, m1_err);
      end
    end
    s_drive(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    checks++;
    if (m1_err !== 1'b1) begin
      errors++;
      $display("FAIL err_passthru: err=%b expected 1", m1_err);
    end
    tick();
    m_idle(1);
    s_drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Complete one master-0 transfer so master 1 would win the next tie without a reset.
    m_drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 3'b000, 2'b00);
    tick();
    s_drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    m_idle(0);
    s_drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    m_drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'hF, 3'b000, 2'b00);
    tick();
    checks++;
    if (io_cyc !== 1'b1 || io_adr !== 32'h0000_0404) begin
      errors++;
      $display("FAIL rstmid_pre: cyc=%b adr=%h expected 1 00000404", io_cyc, io_adr);
    end
    rst = 1'b1;
    m_drive(1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF, 3'b000, 2'b00);
    s_drive(1'b1, 1'b0, 1'b0, 32'h7777_0000);
    tick();
    checks++;
    if (io_cyc !== 1'b0 || io_stb !== 1'b0 || io_adr !== 32'h0 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_io: cyc=%b stb=%b adr=%h ack0=%b expected 0 0 0 0", io_cyc,
               io_stb, io_adr, m0_ack);
    end
    rst = 1'b0;
    s_drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checks++;
    if (io_cyc !== 1'b1 || io_adr !== 32'h0000_0404) begin
      errors++;
      $display("FAIL rstmid_prio0: cyc=%b adr=%h expected 1 00000404", io_cyc, io_adr);
    end
    do_reset();
  endtask

  task automatic test_random();
    int own = -1;
    int last = -1;
    int waitc = 0;
    int r;
    bit mcyc[2], mstb[2], pc[2], rp[2];
    logic [31:0] madr[2], mdat[2];
    logic [3:0]  msel[2];
    logic        mwe[2];
    logic [2:0]  mcti[2];
    logic [1:0]  mbte[2];
    int          beats[2];
    logic        a, e, y;
    logic [75:0] exp_route;
    logic [2:0]  exp_r0, exp_r1;
    logic [31:0] d;
    do_reset();
    for (int m = 0; m < 2; m++) begin
      mcyc[m] = 0; mstb[m] = 0; pc[m] = 0; rp[m] = 0; beats[m] = 0;
      madr[m] = '0; mdat[m] = '0; msel[m] = '0; mwe[m] = 0; mcti[m] = '0; mbte[m] = '0;
    end
    for (int i = 0; i < 400; i++) begin
      tick();
      // Arbitration rules applied to what the arbiter sampled at this edge.
      if (own < 0) begin
        if (pc[0] && pc[1]) own = (last == 0) ? 1 : 0;
        else if (pc[0]) own = 0;
        else if (pc[1]) own = 1;
      end else if (!pc[own]) begin
        last = own;
        own = -1;
      end
      for (int m = 0; m < 2; m++) begin
        if (mcyc[m]) begin
          if (rp[m]) begin
            beats[m]--;
            if (beats[m] == 0) begin
              mcyc[m] = 0;
              mstb[m] = 0;
            end else begin
              madr[m] = madr[m] + 32'd4;
            end
          end
        end else if ($urandom_range(2) == 0) begin
          mcyc[m] = 1; mstb[m] = 1;
          madr[m] = $urandom; mdat[m] = $urandom; msel[m] = 4'($urandom);
          mwe[m] = 1'($urandom);
          mcti[m] = ($urandom_range(1) == 0) ? 3'b000 : 3'b010;
          mbte[m] = 2'($urandom);
          beats[m] = $urandom_range(1, 3);
        end
        m_drive(m, mcyc[m], mstb[m], mwe[m], madr[m], mdat[m], msel[m], mcti[m], mbte[m]);
      end
      a = 0; e = 0; y = 0;
      if (own >= 0 && mstb[own]) begin
        r = $urandom_range(7);
        if (waitc >= 2 && r < 2) r = 2;
        if (r < 2) waitc++;
        else waitc = 0;
        a = (r >= 2 && r <= 5); e = (r == 6); y = (r == 7);
      end else begin
        waitc = 0;
        // Stray responses while idle must not reach either master.
        if (own < 0) begin
          a = ($urandom_range(3) == 0); e = ($urandom_range(3) == 0);
          y = ($urandom_range(3) == 0);
        end
      end
      d = $urandom;
      s_drive(a, e, y, d);
      #1;
      if (own >= 0)
        exp_route = {madr[own], mdat[own], msel[own], mwe[own], mcyc[own], mstb[own],
                     mcti[own], mbte[own]};
      else
        exp_route = '0;
      exp_r0 = (own == 0) ? {a, e, y} : 3'b000;
      exp_r1 = (own == 1) ? {a, e, y} : 3'b000;
      checks++;
      if ({io_adr, io_dat, io_sel, io_we, io_cyc, io_stb, io_cti, io_bte} !== exp_route) begin
        errors++;
        $display("FAIL rand_route: cycle %0d got %h expected %h", i,
                 {io_adr, io_dat, io_sel, io_we, io_cyc, io_stb, io_cti, io_bte}, exp_route);
      end
      checks++;
      if ({m0_ack, m0_err, m0_rty} !== exp_r0) begin
        errors++;
        $display("FAIL rand_resp0: cycle %0d got %b expected %b", i,
                 {m0_ack, m0_err, m0_rty}, exp_r0);
      end
      checks++;
      if ({m1_ack, m1_err, m1_rty} !== exp_r1) begin
        errors++;
        $display("FAIL rand_resp1: cycle %0d got %b expected %b", i,
                 {m1_ack, m1_err, m1_rty}, exp_r1);
      end
      checks++;
      if (m0_dat_o !== d || m1_dat_o !== d) begin
        errors++;
        $display("FAIL rand_dat: cycle %0d got %h/%h expected %h", i, m0_dat_o, m1_dat_o, d);
      end
      for (int m = 0; m < 2; m++) begin
        rp[m] = (own == m) && mstb[m] && (a || e || y);
        pc[m] = mcyc[m];
      end
    end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    m_idle(0);
    m_idle(1);
    s_drive(1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
